// File: rtl/music_sequencer_pkg.sv
// Shared definitions for the music sequencer.
// Holds the mode encoding seen on the 'mode' input and the note frequency
// to oscillator phase-increment conversion used by every playback path.
package music_sequencer_pkg;

  localparam logic [2:0] MODE_ORDER  = 3'd0;
  localparam logic [2:0] MODE_RANDOM = 3'd1;
  localparam logic [2:0] MODE_CHOOSE = 3'd2;
  localparam logic [2:0] MODE_RECORD = 3'd3;
  localparam logic [2:0] MODE_REPLAY = 3'd4;
  localparam logic [2:0] MODE_LIVE   = 3'd5;

  // floor(note * 2^acc_w / sample_rate). The 64-bit working width covers
  // any DATA_W+ACC_W up to 64, so nothing is lost before the caller
  // truncates the result to the accumulator width.
  function automatic logic [63:0] freq_to_inc(input logic [63:0] note,
                                              input int acc_w,
                                              input int sample_rate);
    return (note << acc_w) / 64'(sample_rate);
  endfunction

endpackage

// File: rtl/music_sequencer_rec_buffer.sv
// Record take storage for the music sequencer.
// Simple dual-port RAM: synchronous write port and a registered read port
// (read data appears one clk after rd_addr).
// Ports:
//   clk      system clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  note written
//   rd_addr  read address
//   rd_data  registered read data
module music_sequencer_rec_buffer #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array: an empty take is tracked by the record count
  // in the parent, so stale contents are never played.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/music_sequencer.sv
// Parametrised note sequencer for the audio player.
// Steps through NUM_SONGS song ROMs at the note tick rate, or records and
// replays notes from the keyboard path, and emits a registered phase
// increment for the downstream oscillator.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   step_en          one-cycle note tick
//   pause            freeze position and silence output
//   repeat_one       loop the current song
//   mode             0 order, 1 random, 2 choose, 3 record, 4 replay, 5 live
//   choice, rand_in  song index for modes 2 and 1
//   rom_addr         shared ROM read address
//   rom_data         per-ROM note data, valid 1 clk after rom_addr
//   key_valid        new key note strobe
//   key_note         current key frequency
//   phase_inc        registered oscillator increment
//   cur_song         currently selected song
//   song_end         pulse when the last note of a song is played
//   rec_count        notes recorded in the current take
//   rec_full         record buffer full
module music_sequencer
  import music_sequencer_pkg::*;
#(
  parameter int NUM_SONGS   = 4,
  parameter int SONG_W      = 2,
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 16,
  parameter int ACC_W       = 16,
  parameter int SAMPLE_RATE = 48000,
  parameter logic [NUM_SONGS*ADDR_W-1:0] SONG_LEN =
    {11'd270, 11'd220, 11'd260, 11'd260},
  parameter int REC_DEPTH   = 512,
  parameter int HOLD        = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        step_en,
  input  logic                        pause,
  input  logic                        repeat_one,
  input  logic [2:0]                  mode,
  input  logic [SONG_W-1:0]           choice,
  input  logic [SONG_W-1:0]           rand_in,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [NUM_SONGS*DATA_W-1:0] rom_data,
  input  logic                        key_valid,
  input  logic [DATA_W-1:0]           key_note,
  output logic [ACC_W-1:0]            phase_inc,
  output logic [SONG_W-1:0]           cur_song,
  output logic                        song_end,
  output logic [ADDR_W-1:0]           rec_count,
  output logic                        rec_full
);

  localparam int RA_W   = $clog2(REC_DEPTH);
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [SONG_W:0]   SONGS_EXT = (SONG_W+1)'(NUM_SONGS);
  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

  logic [ADDR_W-1:0] ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [2:0]        prev_mode;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] cur_len;
  logic [DATA_W-1:0] cur_note;
  logic [SONG_W-1:0] rand_song;
  logic [SONG_W-1:0] choice_song;
  logic [SONG_W-1:0] next_song;
  logic              mode_change;
  logic              at_last;

  function automatic logic [ACC_W-1:0] conv(input logic [DATA_W-1:0] note);
    return ACC_W'(freq_to_inc(64'(note), ACC_W, SAMPLE_RATE));
  endfunction

  // Out-of-range song indices fall back to song 0.
  function automatic logic [SONG_W-1:0] clamp_song(input logic [SONG_W-1:0] s);
    return ({1'b0, s} >= SONGS_EXT) ? '0 : s;
  endfunction

  music_sequencer_rec_buffer #(
    .DEPTH  (REC_DEPTH),
    .DATA_W (DATA_W),
    .AW     (RA_W)
  ) u_rec_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (rec_count[RA_W-1:0]),
    .wr_data (key_note),
    .rd_addr (ptr[RA_W-1:0]),
    .rd_data (rd_data)
  );

  // Current song's length and note, and the song that follows song_end.
  // A write only happens on a steady (not just entered) record cycle with
  // room left, so the entry edge of a new take never stores a stale strobe.
  always_comb begin
    cur_len     = SONG_LEN[int'(cur_song)*ADDR_W +: ADDR_W];
    cur_note    = rom_data[int'(cur_song)*DATA_W +: DATA_W];
    rand_song   = clamp_song(rand_in);
    choice_song = clamp_song(choice);
    mode_change = (mode != prev_mode);
    at_last     = (rom_addr == cur_len - ADDR_W'(1));
    next_song   = cur_song;
    if (!repeat_one) begin
      case (mode)
        MODE_RANDOM: next_song = rand_song;
        MODE_CHOOSE: next_song = choice_song;
        default:     next_song = (cur_song == LAST_SONG) ? '0 : cur_song + SONG_W'(1);
      endcase
    end
    wr_en = !reset && !pause && !mode_change && (mode == MODE_RECORD) &&
            key_valid && !rec_full;
  end

  // Main sequencing register. Priority: reset, pause, mode entry, then the
  // per-mode behaviour. prev_mode is frozen while paused so a mode change
  // made during pause is applied once playback resumes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr  <= '0;
      phase_inc <= '0;
      cur_song  <= '0;
      song_end  <= 1'b0;
      rec_count <= '0;
      rec_full  <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
      prev_mode <= MODE_ORDER;
    end else if (pause) begin
      phase_inc <= '0;
      song_end  <= 1'b0;
    end else if (mode_change) begin
      prev_mode <= mode;
      rom_addr  <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      song_end  <= 1'b0;
      if (mode == MODE_RANDOM) begin
        cur_song <= rand_song;
      end
      if (mode == MODE_CHOOSE) begin
        cur_song <= choice_song;
      end
      if (mode == MODE_RECORD) begin
        rec_count <= '0;
        rec_full  <= 1'b0;
      end
    end else begin
      song_end <= 1'b0;
      case (mode)
        MODE_ORDER, MODE_RANDOM, MODE_CHOOSE: begin
          if ((mode == MODE_CHOOSE) && (choice_song != cur_song)) begin
            cur_song <= choice_song;
            rom_addr <= '0;
          end else if (step_en) begin
            phase_inc <= conv(cur_note);
            if (at_last) begin
              rom_addr <= '0;
              song_end <= 1'b1;
              cur_song <= next_song;
            end else begin
              rom_addr <= rom_addr + ADDR_W'(1);
            end
          end
        end
        MODE_RECORD: begin
          phase_inc <= conv(key_note);
          if (wr_en) begin
            rec_count <= rec_count + ADDR_W'(1);
            if (rec_count == ADDR_W'(REC_DEPTH - 1)) begin
              rec_full <= 1'b1;
            end
          end
        end
        MODE_REPLAY: begin
          // ptr moves on the step that finishes a note, which issues the
          // buffer read well before the next step needs it.
          if (rec_count == '0) begin
            phase_inc <= '0;
          end else if (step_en) begin
            phase_inc <= conv(rd_data);
            if (hold_cnt == HOLD_W'(HOLD - 1)) begin
              hold_cnt <= '0;
              ptr <= (ptr == rec_count - ADDR_W'(1)) ? '0 : ptr + ADDR_W'(1);
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end
        MODE_LIVE: begin
          phase_inc <= conv(key_note);
        end
        default: begin
          phase_inc <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer: 3 songs of length {3,2,10},
// an 8-entry record buffer and HOLD=4. A behavioural model tracks song
// position, the recorded take and replay progress; a compare process checks
// every output each cycle, and directed steps pin hand-computed values.
module tb_music_sequencer;

  localparam int NS    = 3;
  localparam int DEPTH = 8;
  localparam int HOLDN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        step_en;
  logic        pause;
  logic        repeat_one;
  logic [2:0]  mode;
  logic [1:0]  choice;
  logic [1:0]  rand_in;
  logic [10:0] rom_addr;
  logic [47:0] rom_data;
  logic        key_valid;
  logic [15:0] key_note;
  logic [15:0] phase_inc;
  logic [1:0]  cur_song;
  logic        song_end;
  logic [10:0] rec_count;
  logic        rec_full;

  int checks;
  int failures;
  bit checking;

  int song_len [NS] = '{3, 2, 10};
  int rep_exp [3] = '{357, 401, 450};

  int m_phase, m_addr, m_song, m_end, m_ptr, m_hold, m_mode;
  int m_buf [$];

  music_sequencer #(
    .NUM_SONGS   (NS),
    .SONG_W      (2),
    .ADDR_W      (11),
    .DATA_W      (16),
    .ACC_W       (16),
    .SAMPLE_RATE (48000),
    .SONG_LEN    ({11'd10, 11'd2, 11'd3}),
    .REC_DEPTH   (DEPTH),
    .HOLD        (HOLDN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .step_en    (step_en),
    .pause      (pause),
    .repeat_one (repeat_one),
    .mode       (mode),
    .choice     (choice),
    .rand_in    (rand_in),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .key_valid  (key_valid),
    .key_note   (key_note),
    .phase_inc  (phase_inc),
    .cur_song   (cur_song),
    .song_end   (song_end),
    .rec_count  (rec_count),
    .rec_full   (rec_full)
  );

  always #5 clk = ~clk;

  // Song contents: song 0 is 440,1000,440; songs 1 and 2 are ramps.
  function automatic int rom_note(int s, int a);
    if (s == 0) return (a == 1) ? 1000 : 440;
    else if (s == 1) return 500 + 100 * a;
    else return 1000 + 50 * a;
  endfunction

  function automatic int inc_of(int n);
    return int'((longint'(n) * 65536) / 48000);
  endfunction

  function automatic int pick(int s);
    return (s >= NS) ? 0 : s;
  endfunction

  // ROMs with one clk read latency.
  always @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      rom_data[s*16 +: 16] <= 16'(rom_note(s, int'(rom_addr)));
    end
  end

  // Behavioural model: position within a song as a table lookup, the take
  // as a queue, replay as a note index advancing every HOLD steps.
  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_addr = 0; m_song = 0; m_end = 0;
      m_ptr = 0; m_hold = 0; m_mode = 0;
      m_buf.delete();
    end else if (pause) begin
      m_phase = 0;
      m_end = 0;
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode);
      m_addr = 0; m_ptr = 0; m_hold = 0; m_end = 0;
      if (m_mode == 1) m_song = pick(int'(rand_in));
      if (m_mode == 2) m_song = pick(int'(choice));
      if (m_mode == 3) m_buf.delete();
    end else begin
      m_end = 0;
      if (m_mode <= 2) begin
        if (m_mode == 2 && pick(int'(choice)) != m_song) begin
          m_song = pick(int'(choice));
          m_addr = 0;
        end else if (step_en) begin
          m_phase = inc_of(rom_note(m_song, m_addr));
          m_addr++;
          if (m_addr == song_len[m_song]) begin
            m_addr = 0;
            m_end = 1;
            if (!repeat_one) begin
              if (m_mode == 0) m_song = (m_song + 1) % NS;
              else if (m_mode == 1) m_song = pick(int'(rand_in));
              else m_song = pick(int'(choice));
            end
          end
        end
      end else if (m_mode == 3) begin
        m_phase = inc_of(int'(key_note));
        if (key_valid && m_buf.size() < DEPTH) m_buf.push_back(int'(key_note));
      end else if (m_mode == 4) begin
        if (m_buf.size() == 0) begin
          m_phase = 0;
        end else if (step_en) begin
          m_phase = inc_of(m_buf[m_ptr]);
          m_hold++;
          if (m_hold == HOLDN) begin
            m_hold = 0;
            m_ptr = (m_ptr + 1) % m_buf.size();
          end
        end
      end else if (m_mode == 5) begin
        m_phase = inc_of(int'(key_note));
      end else begin
        m_phase = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkBoth(input string name, input int dut_val, input int model_val,
                           input int expected);
    checkOutput(name, dut_val, expected);
    checkOutput({name, "_model"}, model_val, expected);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("phase_inc", int'(phase_inc), m_phase);
      checkOutput("rom_addr", int'(rom_addr), m_addr);
      checkOutput("cur_song", int'(cur_song), m_song);
      checkOutput("song_end", int'(song_end), m_end);
      checkOutput("rec_count", int'(rec_count), m_buf.size());
      checkOutput("rec_full", int'(rec_full), int'(m_buf.size() == DEPTH));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One idle clk then a one-clk step pulse; outputs reflect the step on return.
  task automatic do_step();
    @(negedge clk);
    step_en = 1'b1;
    @(negedge clk);
    step_en = 1'b0;
  endtask

  task automatic key_strobe(input int note);
    key_note = 16'(note);
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic applyStimulus();
    // Order mode through song 0: 440,1000,440.
    do_step();
    checkBoth("s0_step1", int'(phase_inc), m_phase, 600);
    do_step();
    checkBoth("s0_step2", int'(phase_inc), m_phase, 1365);
    do_step();
    checkBoth("s0_step3", int'(phase_inc), m_phase, 600);
    checkBoth("s0_end", int'(song_end), m_end, 1);
    checkBoth("s0_next_song", int'(cur_song), m_song, 1);
    checkBoth("s0_addr_wrap", int'(rom_addr), m_addr, 0);
    do_step();
    checkBoth("s1_step1", int'(phase_inc), m_phase, 682);
    do_step();
    checkBoth("s1_to_s2", int'(cur_song), m_song, 2);

    // Song 2 with repeat_one, pausing at address 7.
    repeat_one = 1'b1;
    for (int i = 0; i < 7; i++) do_step();
    checkBoth("s2_addr7", int'(rom_addr), m_addr, 7);
    checkBoth("s2_note6", int'(phase_inc), m_phase, 1774);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) do_step();
    checkBoth("pause_phase", int'(phase_inc), m_phase, 0);
    checkBoth("pause_addr", int'(rom_addr), m_addr, 7);
    pause = 1'b0;
    do_step();
    checkBoth("resume_note7", int'(phase_inc), m_phase, 1843);
    do_step();
    do_step();
    checkBoth("s2_last", int'(phase_inc), m_phase, 1979);
    checkBoth("repeat_end", int'(song_end), m_end, 1);
    checkBoth("repeat_song", int'(cur_song), m_song, 2);
    repeat_one = 1'b0;
    for (int i = 0; i < 10; i++) do_step();
    checkBoth("order_wrap", int'(cur_song), m_song, 0);

    // Random mode: entry loads rand_in, song_end samples it, 3 clamps to 0.
    rand_in = 2'd1;
    mode = 3'd1;
    idle(2);
    checkBoth("rand_entry", int'(cur_song), m_song, 1);
    rand_in = 2'd2;
    do_step();
    do_step();
    checkBoth("rand_pick2", int'(cur_song), m_song, 2);
    rand_in = 2'd3;
    for (int i = 0; i < 10; i++) do_step();
    checkBoth("rand_clamp", int'(cur_song), m_song, 0);

    // Choose mode: a change of choice restarts at address 0.
    choice = 2'd1;
    mode = 3'd2;
    idle(2);
    do_step();
    checkBoth("choose_s1", int'(phase_inc), m_phase, 682);
    choice = 2'd2;
    idle(2);
    checkBoth("choose_addr0", int'(rom_addr), m_addr, 0);
    do_step();
    checkBoth("choose_s2", int'(phase_inc), m_phase, 1365);

    // Record three notes, then replay each for HOLD steps.
    mode = 3'd3;
    idle(2);
    key_strobe(262);
    key_strobe(294);
    key_strobe(330);
    checkBoth("rec_count3", int'(rec_count), m_buf.size(), 3);
    checkBoth("rec_monitor", int'(phase_inc), m_phase, 450);
    mode = 3'd4;
    idle(2);
    for (int i = 0; i < 12; i++) begin
      do_step();
      checkOutput("replay_note", int'(phase_inc), rep_exp[i / HOLDN]);
    end
    do_step();
    checkBoth("replay_wrap", int'(phase_inc), m_phase, 357);

    // Overflow a new take, then reset in the middle of it.
    mode = 3'd3;
    idle(2);
    for (int i = 0; i < DEPTH + 2; i++) key_strobe(100 + 10 * i);
    checkBoth("full_count", int'(rec_count), m_buf.size(), DEPTH);
    checkBoth("full_flag", int'(rec_full), int'(m_buf.size() == DEPTH), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkBoth("rst_count", int'(rec_count), m_buf.size(), 0);
    checkBoth("rst_full", int'(rec_full), int'(m_buf.size() == DEPTH), 0);
    checkBoth("rst_phase", int'(phase_inc), m_phase, 0);
    idle(2);
    key_strobe(262);
    checkBoth("after_rst_count", int'(rec_count), m_buf.size(), 1);
    pause = 1'b1;
    key_strobe(294);
    idle(1);
    checkBoth("pause_rec_count", int'(rec_count), m_buf.size(), 1);
    checkBoth("pause_rec_phase", int'(phase_inc), m_phase, 0);
    pause = 1'b0;

    // Live and unused modes.
    key_note = 16'd440;
    mode = 3'd5;
    idle(3);
    checkBoth("live", int'(phase_inc), m_phase, 600);
    mode = 3'd6;
    idle(3);
    checkBoth("mode6", int'(phase_inc), m_phase, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    checking = 1'b0;
    reset = 1'b1;
    step_en = 1'b0;
    pause = 1'b0;
    repeat_one = 1'b0;
    mode = 3'd0;
    choice = 2'd0;
    rand_in = 2'd0;
    key_valid = 1'b0;
    key_note = 16'd0;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    checkOutput("reset_phase", int'(phase_inc), 0);
    checkOutput("reset_addr", int'(rom_addr), 0);
    checkOutput("reset_song", int'(cur_song), 0);
    checkOutput("reset_count", int'(rec_count), 0);
    reset = 1'b0;
    applyStimulus();
    idle(2);
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
- Parametrised note sequencer for the audio player.
- Steps through N song ROMs at the note tick rate, or records/replays notes from the PS/2 keyboard path. Emits a registered phase increment for the downstream sample-rate oscillator.
- Successor to the fixed 4-song player: adds parametrised song count and widths, a per-song length table, a repeat-one mode, a song_end pulse, and a clearable record take with a full flag.
- Sits between the song ROMs, the keyboard decoder and the waveform generator.

Parameters:
NUM_SONGS, 4, number of song ROMs (2..16)
SONG_W, 2, song index width, equal to clog2(NUM_SONGS)
ADDR_W, 11, ROM and record address width
DATA_W, 16, note frequency width in Hz
ACC_W, 16, oscillator accumulator width
SAMPLE_RATE, 48000, oscillator sample rate in Hz
SONG_LEN, {260,260,220,270}, packed NUM_SONGS*ADDR_W vector of note counts; entry 0 is in the LSBs
REC_DEPTH, 512, record buffer entries
HOLD, 4, note ticks per recorded note on playback

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
step_en  in  1  one-cycle note tick; consecutive pulses are at least 2 clk apart
pause  in  1  freeze position and silence output
repeat_one  in  1  loop the current song instead of advancing
mode  in  3  0 order, 1 random, 2 choose, 3 record, 4 replay, 5 live
choice  in  SONG_W  song used in mode 2
rand_in  in  SONG_W  random song index used in mode 1
rom_addr  out  ADDR_W  read address shared by all song ROMs
rom_data  in  NUM_SONGS*DATA_W  per-ROM note data, valid 1 clk after rom_addr
key_valid  in  1  one-cycle strobe: a new key note is present
key_note  in  DATA_W  current key frequency
phase_inc  out  ACC_W  registered oscillator increment
cur_song  out  SONG_W  currently selected song
song_end  out  1  one-cycle pulse when the last note of a song is played
rec_count  out  ADDR_W  number of notes recorded
rec_full  out  1  record buffer is full

Behaviour:
- Reset values: all outputs are 0, the record buffer is empty, and the hold counter is 0.
- Conversion: phase_inc <= floor(note * 2^ACC_W / SAMPLE_RATE), computed at full width (DATA_W+ACC_W bits) and truncated to ACC_W. Registered, so output latency is 1 clk after the selecting step.
- Any change of mode zeroes rom_addr, the playback pointer and the hold counter on the next clk. phase_inc holds its value until the next step.
- pause=1 has top priority:
  - phase_inc <= 0.
  - Addresses, pointers and song hold their values.
  - Record writes are ignored.
  - step_en is ignored.
- Modes 0, 1 and 2 (song play), on step_en:
  - phase_inc <= conv(rom_data slice cur_song).
  - If rom_addr == SONG_LEN[cur_song]-1: rom_addr <= 0 and song_end pulses.
  - Otherwise rom_addr increments.
- Next song after song_end:
  - If repeat_one=1: cur_song is unchanged in every mode.
  - Mode 0: cur_song+1, wrapping from NUM_SONGS-1 to 0.
  - Mode 1: rand_in sampled at song_end; if rand_in >= NUM_SONGS, use 0.
  - Mode 2: cur_song <= choice every clk. A change of choice resets rom_addr to 0.
- Entry into mode 1 loads cur_song from rand_in. Entry into mode 0 keeps cur_song.
- Mode 3 (record):
  - Entering mode 3 clears rec_count and rec_full (new take).
  - Each key_valid writes key_note at address rec_count, then rec_count increments.
  - When rec_count reaches REC_DEPTH, rec_full=1 and further key_valid strobes are dropped.
  - phase_inc follows conv(key_note), so the player hears the take while recording.
- Mode 4 (replay):
  - If rec_count == 0, phase_inc = 0.
  - Otherwise on each step, phase_inc <= conv(buffer[ptr]) and the hold counter increments.
  - When the hold counter reaches HOLD-1, it clears and ptr increments; ptr wraps to 0 after rec_count-1.
  - Buffer read latency is 1 clk, so the read is issued on the ptr update.
- Mode 5 (live): phase_inc <= conv(key_note) every clk, with no step gating.
- Modes 6 and 7: phase_inc <= 0; state otherwise holds.
- song_end never asserts in modes 3, 4 and 5.
- Reset asserted mid-song or mid-record returns every register to its reset value on the same edge; the recorded take is lost (rec_count=0).

Decomposition:
- Shared package:
  - mode encoding constants MODE_ORDER, MODE_RANDOM, MODE_CHOOSE, MODE_RECORD, MODE_REPLAY, MODE_LIVE.
  - Function freq_to_inc(note) parametrised by ACC_W and SAMPLE_RATE.
- Sub-module rec_buffer: simple dual-port RAM, REC_DEPTH x DATA_W, with a synchronous write port and a registered read port (1 clk latency), instantiated once.

Test Plan:
- Mode 0, NUM_SONGS=4, lengths {3,2,2,2} (override), ROM0 contents 440,1000,440 -> phase_inc values 600,1365,600 on successive steps. song_end pulses once after the 3rd step. cur_song becomes 1 and rom_addr returns to 0.
- Mode 0 with repeat_one=1, playing song 3 -> after song_end, cur_song stays 3. With repeat_one=0 it wraps to 0.
- Mode 1 with rand_in=2 at song_end -> cur_song=2. With NUM_SONGS=3 and rand_in=3 -> cur_song=0.
- pause asserted for 5 steps mid-song at rom_addr=7 -> phase_inc=0 and rom_addr stays 7. After release, the next step reads address 7.
- Mode 3 with 3 key_valid strobes (262, 294, 330), then mode 4 with HOLD=4 -> rec_count=3. Each note is output for 4 steps (357,401,450, i.e. 262->357, 294->401, 330->450), then the sequence wraps to 262.
- Record REC_DEPTH+2 strobes -> rec_count=REC_DEPTH and rec_full=1; the last 2 strobes are dropped. Synchronous reset mid-take -> rec_count=0, rec_full=0 and phase_inc=0 on the following clk.
